// File: rtl/rect_bounce_ctl.sv
// Motion controller for the on-screen rectangle: gravity fall, lossy floor bounces,
// and a final rest on the floor. Position only advances on a tick strobe.
module rect_bounce_ctl #(
  parameter int unsigned Y_MAX      = 537,
  parameter int unsigned ACCEL      = 1,
  parameter int unsigned VEL_MAX    = 64,
  parameter int unsigned LOSS_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] x_in,
  input  logic [11:0] y_in,
  input  logic        tick,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [2:0]  state,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_DOWN   = 3'b001,
    S_UP     = 3'b010,
    S_BOTTOM = 3'b011,
    S_BOUNCE = 3'b100
  } state_e;

  localparam logic [12:0] YMAX_W = 13'(Y_MAX);
  localparam logic [11:0] YMAX_N = 12'(Y_MAX);
  localparam logic [12:0] ACC_W  = 13'(ACCEL);
  localparam logic [11:0] ACC_N  = 12'(ACCEL);
  localparam logic [12:0] VMAX_W = 13'(VEL_MAX);

  state_e      state_q, state_d;
  logic [11:0] xpos_q, xpos_d;
  logic [11:0] ypos_q, ypos_d;
  logic [11:0] vel_q, vel_d;
  logic        busy_q, busy_d;

  // 13-bit views keep every add/compare free of wrap-around
  logic [12:0] vel_w, ypos_w, y_in_w;
  logic [12:0] vel_inc, vel_step, y_fall;
  logic [11:0] y_start, vel_loss, y_rise, vel_dec;

  assign vel_w    = {1'b0, vel_q};
  assign ypos_w   = {1'b0, ypos_q};
  assign y_in_w   = {1'b0, y_in};
  assign vel_inc  = vel_w + ACC_W;
  assign vel_step = (vel_inc > VMAX_W) ? VMAX_W : vel_inc;
  assign y_fall   = ypos_w + vel_step;
  assign y_start  = (y_in_w > YMAX_W) ? YMAX_N : y_in;

  // Only used when vel >= 2, vel <= ypos and vel > ACCEL, so 12 bits cannot underflow
  assign vel_loss = vel_q - (vel_q >> LOSS_SHIFT) - 12'd1;
  assign y_rise   = ypos_q - vel_q;
  assign vel_dec  = vel_q - ACC_N;

  always_comb begin
    state_d = state_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    vel_d   = vel_q;
    case (state_q)
      S_IDLE, S_BOTTOM: begin
        if (start) begin
          xpos_d  = x_in;
          ypos_d  = y_start;
          vel_d   = '0;
          state_d = S_DOWN;
        end
      end
      S_DOWN: begin
        if (tick) begin
          vel_d = vel_step[11:0];
          if (y_fall >= YMAX_W) begin
            ypos_d  = YMAX_N;
            state_d = S_BOUNCE;
          end else begin
            ypos_d = y_fall[11:0];
          end
        end
      end
      S_BOUNCE: begin
        if (vel_q <= 12'd1 || vel_loss == 12'd0) begin
          vel_d   = '0;
          state_d = S_BOTTOM;
        end else begin
          vel_d   = vel_loss;
          state_d = S_UP;
        end
      end
      S_UP: begin
        if (tick) begin
          if (vel_q > ypos_q) begin
            ypos_d  = '0;
            vel_d   = '0;
            state_d = S_DOWN;
          end else if (vel_w <= ACC_W) begin
            ypos_d  = y_rise;
            vel_d   = '0;
            state_d = S_DOWN;
          end else begin
            ypos_d = y_rise;
            vel_d  = vel_dec;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_DOWN) || (state_d == S_UP) || (state_d == S_BOUNCE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      xpos_q  <= '0;
      ypos_q  <= '0;
      vel_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      vel_q   <= vel_d;
      busy_q  <= busy_d;
    end
  end

  assign xpos  = xpos_q;
  assign ypos  = ypos_q;
  assign state = state_q;
  assign busy  = busy_q;

endmodule
